// File: rtl/sparc_mulx_pkg.sv
// Shared types and defaults for the SPARC multiplier front end.
// The accumulator feature is enabled by defining SPARC_MULX_ACC_EN.
package sparc_mulx_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_NREQ  = 2;
    localparam int DEF_LAT   = 5;
    localparam int MAX_WIDTH = 64;
    localparam int MAX_NREQ  = 8;
    localparam int ID_W      = $clog2(MAX_NREQ);

    // Sized for the widest build; narrower builds zero-extend into it.
    typedef struct packed {
        logic                     vld;
        logic [ID_W-1:0]          id;
        logic                     acc;
        logic [2*MAX_WIDTH-1:0]   product;
    } stage_t;

    function automatic int acc_w_default(input int width);
        return 2 * width + 8;
    endfunction

endpackage

// File: rtl/sparc_mulx_rr_arb.sv
// NREQ-way round-robin arbiter; masked requesters are skipped this cycle.
// Search starts one past the last winner; ptr resets so requester 0 wins first.
module sparc_mulx_rr_arb
    import sparc_mulx_pkg::*;
#(
    parameter int NREQ = DEF_NREQ
) (
    input  logic             rclk,
    input  logic             arst_l,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  mask,
    output logic [NREQ-1:0]  gnt,
    output logic             gnt_vld,
    output logic [ID_W-1:0]  gnt_id
);

    logic [ID_W-1:0] ptr_reg;
    logic [NREQ-1:0] elig;
    int              idx;

    assign elig = req & ~mask;

    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr_reg) + k) % NREQ;
            if (!gnt_vld && arst_l && elig[idx]) begin
                gnt_vld  = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            ptr_reg <= ID_W'(NREQ - 1);
        end else if (gnt_vld) begin
            ptr_reg <= gnt_id;
        end
    end

endmodule

// File: rtl/sparc_mulx_arb.sv
// Multiplier front end: round-robin issue into a LAT-cycle unsigned multiply pipe.
// Define SPARC_MULX_ACC_EN to add the MAC accumulator with shift/clear service.
module sparc_mulx_arb
    import sparc_mulx_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ,
    parameter int LAT   = DEF_LAT,
    parameter int ACC_W = acc_w_default(WIDTH)
) (
    input  logic                   rclk,
    input  logic                   arst_l,
    input  logic [NREQ-1:0]        req_vld,
    input  logic [NREQ-1:0]        req_acc,
    input  logic [NREQ*WIDTH-1:0]  req_op1,
    input  logic [NREQ*WIDTH-1:0]  req_op2,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        ack,
    output logic [WIDTH-1:0]       data_out,
    input  logic                   acc_shf,
    output logic                   acc_shf_ack,
    input  logic                   acc_rst,
    output logic                   busy
);

    // The last stage feeds the output register, so LAT-1 stages give T+LAT acks.
    localparam int NSTG = LAT - 1;

    stage_t             pipe [NSTG];
    stage_t             stage_in;
    stage_t             last;
    logic [NREQ-1:0]    mac_mask;
    logic               gnt_vld;
    logic [ID_W-1:0]    gnt_id;
    logic [WIDTH-1:0]   op1;
    logic [WIDTH-1:0]   op2;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   result;
    logic [NREQ-1:0]    ack_next;
    logic [NSTG-1:0]    stg_vld;
    logic [NSTG-1:0]    stg_mac;
    logic               unused_bits;

    sparc_mulx_rr_arb #(.NREQ(NREQ)) u_arb (
        .rclk    (rclk),
        .arst_l  (arst_l),
        .req     (req_vld),
        .mask    (mac_mask),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        op1              = req_op1[int'(gnt_id)*WIDTH +: WIDTH];
        op2              = req_op2[int'(gnt_id)*WIDTH +: WIDTH];
        prod             = {{WIDTH{1'b0}}, op1} * {{WIDTH{1'b0}}, op2};
        stage_in         = '0;
        stage_in.vld     = gnt_vld;
        stage_in.id      = gnt_id;
`ifdef SPARC_MULX_ACC_EN
        stage_in.acc     = |(gnt & req_acc);
`endif
        stage_in.product = (2*MAX_WIDTH)'(prod);
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < NSTG; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= stage_in;
            for (int i = 1; i < NSTG; i++) pipe[i] <= pipe[i-1];
        end
    end

    generate
        for (genvar gi = 0; gi < NSTG; gi++) begin : g_stage_flags
            assign stg_vld[gi] = pipe[gi].vld;
            assign stg_mac[gi] = pipe[gi].vld & pipe[gi].acc;
        end
    endgenerate

    assign last     = pipe[NSTG-1];
    assign busy     = |stg_vld;
    assign ack_next = last.vld ? (NREQ'(1) << last.id) : '0;

`ifdef SPARC_MULX_ACC_EN
    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_sum;
    logic             shf_pending;
    logic             shf_take;

    // A shift waits for the pipe to drain of MAC ops; MAC grants hold off meanwhile.
    assign shf_pending = acc_shf & ~acc_shf_ack;
    assign shf_take    = shf_pending & ~(|stg_mac);
    assign mac_mask    = shf_pending ? req_acc : '0;
    assign acc_sum     = acc_reg + ACC_W'(last.product[2*WIDTH-1:0]);
    assign unused_bits = ^last;

    // acc_rst sampled on the writeback edge wins, so the acked MAC returns zero.
    always_comb begin
        result = last.product[WIDTH-1:0];
        if (last.acc) result = acc_rst ? '0 : acc_sum[WIDTH-1:0];
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            acc_reg     <= '0;
            acc_shf_ack <= 1'b0;
        end else begin
            acc_shf_ack <= shf_take;
            if (acc_rst)                  acc_reg <= '0;
            else if (last.vld && last.acc) acc_reg <= acc_sum;
            else if (shf_take)             acc_reg <= acc_reg >> WIDTH;
        end
    end
`else
    localparam logic [31:0] ACC_W_BITS = 32'(ACC_W);

    assign mac_mask    = '0;
    assign acc_shf_ack = 1'b0;
    assign result      = last.product[WIDTH-1:0];
    assign unused_bits = ^{last, req_acc, acc_shf, acc_rst, stg_mac, ACC_W_BITS[0]};
`endif

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            ack      <= '0;
            data_out <= '0;
        end else begin
            ack <= ack_next;
            if (last.vld) data_out <= result;
        end
    end

endmodule

// File: tb/tb_sparc_mulx_arb.sv
// Scoreboard bench for sparc_mulx_arb; MAC scenarios run when SPARC_MULX_ACC_EN is defined.
`timescale 1ns/1ps
module tb_sparc_mulx_arb;

    localparam int W    = 64;
    localparam int NREQ = 2;
    localparam int LAT  = 5;
`ifdef SPARC_MULX_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic             rclk = 1'b0;
    logic             arst_l;
    logic [NREQ-1:0]  req_vld, req_acc;
    logic [NREQ*W-1:0] req_op1, req_op2;
    logic [NREQ-1:0]  gnt, ack;
    logic [W-1:0]     data_out;
    logic             acc_shf, acc_shf_ack, acc_rst, busy;

    sparc_mulx_arb #(.WIDTH(W), .NREQ(NREQ), .LAT(LAT)) dut (
        .rclk(rclk), .arst_l(arst_l), .req_vld(req_vld), .req_acc(req_acc),
        .req_op1(req_op1), .req_op2(req_op2), .gnt(gnt), .ack(ack),
        .data_out(data_out), .acc_shf(acc_shf), .acc_shf_ack(acc_shf_ack),
        .acc_rst(acc_rst), .busy(busy)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        int           id;
        bit           mac;
        logic [127:0] prod;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    logic [135:0] model_acc = '0;
    logic         rst_prev = 1'b0;
    logic         shf_seen = 1'b0;

    always @(posedge rclk) cyc <= cyc + 1;

    // Scoreboard: push on grant, pop and compare on ack.
    exp_t         mon_e;
    logic [135:0] mon_sum;
    logic [63:0]  mon_d;
    logic [1:0]   mon_a;
    bit           mon_mac;
    int           mon_gid;
    always @(negedge rclk) begin
        if (arst_l) begin
            mon_mac = 1'b0;
            if (ack !== 2'b00) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_ack ack=%b data_out=%h cycle=%0d", ack, data_out, cyc);
                end else begin
                    mon_e   = q.pop_front();
                    mon_sum = model_acc + {8'd0, mon_e.prod};
                    mon_d   = !mon_e.mac ? mon_e.prod[63:0] : (rst_prev ? 64'd0 : mon_sum[63:0]);
                    mon_a   = 2'b01 << mon_e.id;
                    mon_mac = mon_e.mac;
                    checks++;
                    if (ack !== mon_a || data_out !== mon_d || cyc != mon_e.cyc) begin
                        failures++;
                        $display("FAIL ack_result ack=%b data_out=%h cycle=%0d required ack=%b data_out=%h cycle=%0d",
                                 ack, data_out, cyc, mon_a, mon_d, mon_e.cyc);
                    end
                    $display("ack id=%0d mac=%0d data_out=%h cycle=%0d", mon_e.id, mon_e.mac, data_out, cyc);
                end
            end
            if (rst_prev)          model_acc = '0;
            else if (mon_mac)      model_acc = mon_sum;
            else if (acc_shf_ack)  model_acc = model_acc >> W;
            if (acc_shf_ack) shf_seen = 1'b1;
            if (gnt !== 2'b00) begin
                checks++;
                if (!$onehot(gnt) || (gnt & ~req_vld) != 2'b00) begin
                    failures++;
                    $display("FAIL gnt_legal gnt=%b req_vld=%b required one-hot subset", gnt, req_vld);
                end
                mon_gid     = gnt[1] ? 1 : 0;
                mon_e.id    = mon_gid;
                mon_e.mac   = ACC_EN && req_acc[mon_gid];
                mon_e.prod  = {64'd0, req_op1[mon_gid*W +: W]} * {64'd0, req_op2[mon_gid*W +: W]};
                mon_e.cyc   = cyc + LAT;
                q.push_back(mon_e);
            end
        end
        rst_prev = ACC_EN && acc_rst;
    end

    // Tasks start and end one time unit after a rising edge.
    task automatic issue(input int id, input logic [63:0] a, input logic [63:0] b,
                         input logic mac, output int gcyc);
        int n = 0;
        req_op1[id*W +: W] = a;
        req_op2[id*W +: W] = b;
        req_acc[id] = mac;
        req_vld[id] = 1'b1;
        gcyc = -1;
        while (gcyc < 0 && n < 20) begin
            @(negedge rclk);
            if (gnt[id]) gcyc = cyc;
            n++;
            @(posedge rclk); #1;
        end
        req_vld[id] = 1'b0;
        checks++;
        if (gcyc < 0) begin
            failures++;
            $display("FAIL grant_timeout id=%0d granted=no required=yes", id);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((q.size() != 0 || busy) && n < 40) begin
            @(negedge rclk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
        end
        @(posedge rclk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge rclk);
        @(negedge rclk);
        checks += 5;
        if (gnt !== 2'b00)      begin failures++; $display("FAIL reset_gnt gnt=%b required=00", gnt); end
        if (ack !== 2'b00)      begin failures++; $display("FAIL reset_ack ack=%b required=00", ack); end
        if (data_out !== 64'd0) begin failures++; $display("FAIL reset_data data_out=%h required=0", data_out); end
        if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy busy=%b required=0", busy); end
        if (acc_shf_ack !== 1'b0) begin failures++; $display("FAIL reset_shf_ack acc_shf_ack=%b required=0", acc_shf_ack); end
        $display("reset checked gnt=%b ack=%b data_out=%h busy=%b", gnt, ack, data_out, busy);
        @(posedge rclk); #1;
        req_vld = '0;
        acc_shf = 1'b0;
        arst_l  = 1'b1;
    endtask

    task automatic test_fairness();
        logic [1:0] expg;
        req_acc = '0;
        req_vld = 2'b11;
        for (int k = 0; k < 8; k++) begin
            req_op1 = {$urandom, $urandom, $urandom, $urandom};
            req_op2 = {$urandom, $urandom, $urandom, $urandom};
            @(negedge rclk);
            expg = (k % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (gnt !== expg) begin failures++; $display("FAIL fairness_gnt k=%0d gnt=%b required=%b", k, gnt, expg); end
            if (k > 0) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL fairness_busy k=%0d busy=%b required=1", k, busy); end
            end
            @(posedge rclk); #1;
        end
        req_vld = '0;
        wait_drain();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy busy=%b required=0", busy); end
    endtask

    task automatic test_single();
        int t0, g;
        t0 = cyc;
        issue(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, g);
        checks++;
        if (g != t0) begin failures++; $display("FAIL single_gnt_cycle cycle=%0d required=%0d", g, t0); end
        wait_drain();
        repeat (2) @(posedge rclk);
        #1;
        checks++;
        if (data_out !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            failures++;
            $display("FAIL data_hold data_out=%h required=FFFFFFFFFFFFFFFE", data_out);
        end
    endtask

    task automatic test_back_to_back();
        req_acc = '0;
        req_vld = 2'b10;
        for (int k = 0; k < 6; k++) begin
            req_op1[W +: W] = {$urandom, $urandom};
            req_op2[W +: W] = {$urandom, $urandom};
            @(negedge rclk);
            checks++;
            if (gnt !== 2'b10) begin failures++; $display("FAIL b2b_gnt k=%0d gnt=%b required=10", k, gnt); end
            @(posedge rclk); #1;
        end
        req_vld = '0;
        wait_drain();
    endtask

`ifdef SPARC_MULX_ACC_EN
    task automatic test_mac_shift();
        int g, s0, s;
        acc_rst = 1'b1;
        @(posedge rclk); #1;
        acc_rst = 1'b0;
        issue(0, 64'h8000_0000_0000_0000, 64'd4, 1'b1, g);
        wait_drain();
        checks++;
        if (data_out !== 64'd0) begin failures++; $display("FAIL mac_wrap data_out=%h required=0", data_out); end
        acc_shf = 1'b1;
        s0 = cyc;
        s = -1;
        for (int n = 0; n < LAT + 3 && s < 0; n++) begin
            @(negedge rclk);
            if (acc_shf_ack) s = cyc;
            @(posedge rclk); #1;
        end
        acc_shf = 1'b0;
        checks++;
        if (s != s0 + 1) begin failures++; $display("FAIL shf_ack_latency cycle=%0d required=%0d", s, s0 + 1); end
        issue(0, 64'd0, 64'd0, 1'b1, g);
        wait_drain();
        checks++;
        if (data_out !== 64'd2) begin failures++; $display("FAIL mac_after_shift data_out=%h required=2", data_out); end
    endtask

    task automatic test_shift_hazard();
        int t, g0, g1, s;
        issue(0, 64'h1234, 64'h10, 1'b1, t);
        req_op1[0 +: W] = 64'd5;      req_op2[0 +: W] = 64'd7;  req_acc[0] = 1'b1; req_vld[0] = 1'b1;
        req_op1[W +: W] = 64'hABCD;   req_op2[W +: W] = 64'd3;  req_acc[1] = 1'b0; req_vld[1] = 1'b1;
        acc_shf = 1'b1;
        g0 = -1; g1 = -1; s = -1;
        for (int n = 0; n < 20; n++) begin
            @(negedge rclk);
            if (gnt[0] && g0 < 0) g0 = cyc;
            if (gnt[1] && g1 < 0) g1 = cyc;
            if (acc_shf_ack && s < 0) s = cyc;
            @(posedge rclk); #1;
            if (g0 >= 0) req_vld[0] = 1'b0;
            if (g1 >= 0) req_vld[1] = 1'b0;
            if (s >= 0)  acc_shf = 1'b0;
        end
        acc_shf = 1'b0;
        req_vld = '0;
        checks += 3;
        if (s < t + LAT + 1 || s > t + LAT + 2) begin
            failures++; $display("FAIL hazard_shf_ack cycle=%0d required=%0d..%0d", s, t + LAT + 1, t + LAT + 2);
        end
        if (g1 != t + 1) begin failures++; $display("FAIL hazard_plain_gnt cycle=%0d required=%0d", g1, t + 1); end
        if (g0 < s || s < 0) begin failures++; $display("FAIL hazard_mac_withheld cycle=%0d required>=%0d", g0, s); end
        wait_drain();
    endtask

    task automatic test_clear_collision();
        int g;
        issue(0, 64'd7, 64'd9, 1'b1, g);
        repeat (3) @(posedge rclk);
        #1;
        acc_rst = 1'b1;
        @(posedge rclk); #1;
        acc_rst = 1'b0;
        @(negedge rclk);
        checks++;
        if (ack !== 2'b01 || data_out !== 64'd0) begin
            failures++; $display("FAIL clear_collision ack=%b data_out=%h required ack=01 data_out=0", ack, data_out);
        end
        @(posedge rclk); #1;
        issue(0, 64'd3, 64'd5, 1'b1, g);
        wait_drain();
        checks++;
        if (data_out !== 64'd15) begin failures++; $display("FAIL mac_after_clear data_out=%h required=f", data_out); end
    endtask
`else
    task automatic test_acc_disabled();
        int g;
        shf_seen = 1'b0;
        acc_shf  = 1'b1;
        acc_rst  = 1'b1;
        issue(0, 64'd6, 64'd7, 1'b1, g);
        acc_rst = 1'b0;
        wait_drain();
        repeat (3) @(posedge rclk);
        #1;
        acc_shf = 1'b0;
        checks += 2;
        if (data_out !== 64'd42) begin failures++; $display("FAIL plain_when_disabled data_out=%h required=2a", data_out); end
        if (shf_seen !== 1'b0) begin failures++; $display("FAIL shf_ack_disabled acc_shf_ack=1 required=0"); end
    endtask
`endif

    task automatic test_reset_midflight();
        int g;
        issue(0, 64'd5, 64'd5, 1'b0, g);
        @(posedge rclk); #1;
        req_vld   = 2'b11;
        arst_l    = 1'b0;
        q.delete();
        model_acc = '0;
        @(negedge rclk);
        checks++;
        if (gnt !== 2'b00 || ack !== 2'b00 || data_out !== 64'd0 || busy !== 1'b0 || acc_shf_ack !== 1'b0) begin
            failures++;
            $display("FAIL midflight_reset gnt=%b ack=%b data_out=%h busy=%b required all 0", gnt, ack, data_out, busy);
        end
        @(posedge rclk); #1;
        arst_l = 1'b1;
        @(negedge rclk);
        checks++;
        if (gnt !== 2'b01) begin failures++; $display("FAIL ptr_after_reset gnt=%b required=01", gnt); end
        @(posedge rclk); #1;
        req_vld = '0;
        wait_drain();
    endtask

    initial begin
        arst_l  = 1'b0;
        req_vld = 2'b11;
        req_acc = '0;
        req_op1 = {64'd3, 64'd9};
        req_op2 = {64'd4, 64'd8};
        acc_shf = 1'b1;
        acc_rst = 1'b0;
        test_reset();
        test_fairness();
        test_single();
        test_back_to_back();
`ifdef SPARC_MULX_ACC_EN
        test_mac_shift();
        test_shift_hazard();
        test_clear_collision();
`else
        test_acc_disabled();
`endif
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d required=finish", cyc);
        $fatal(1, "simulation time limit");
    end

endmodule
